// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - Shared constants, coefficient type and halving helper for the q = 8380417 NTT datapath
package ntt_pkg;

  localparam int          COEFF_W   = 23;
  localparam logic [22:0] Q         = 23'd8380417;
  localparam logic [23:0] BARRETT_M = 24'd8396807;
  localparam int          BARRETT_K = 46;
  localparam logic [22:0] QINV2     = 23'd4190209;

  typedef logic [COEFF_W-1:0] coeff_t;

  // Multiply by 2^-1 mod q: an odd x becomes even after adding q, so the shift is exact.
  function automatic coeff_t half_mod_q(input coeff_t x, input logic en);
    logic [23:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, Q} : 24'd0);
    return en ? 23'(t >> 1) : x;
  endfunction

endpackage

// File: rtl/bu_intt_if.sv
// rtl/bu_intt_if.sv - Sample-in / result-out bus of the inverse-NTT butterfly
interface bu_intt_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] A_In;
  logic [WIDTH-1:0] B_In;
  logic [WIDTH-1:0] W_In;
  logic             half_en;
  logic             out_valid;
  logic [WIDTH-1:0] A_Out;
  logic [WIDTH-1:0] B_Out;

  modport master (
    output in_valid, A_In, B_In, W_In, half_en,
    input  out_valid, A_Out, B_Out
  );

  modport slave (
    input  in_valid, A_In, B_In, W_In, half_en,
    output out_valid, A_Out, B_Out
  );
endinterface

// File: rtl/bu_intt_mod_mul_q.sv
// rtl/bu_intt_mod_mul_q.sv - Four-register Barrett modular multiplier mod q, valid-free datapath
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t r_o
);

  logic [45:0] p_q;
  logic [23:0] p3_q;
  logic [23:0] t_q;
  logic [23:0] r4_q;
  coeff_t      r5_q;

  logic [45:0] p_d;
  logic [69:0] pm_w;
  logic [23:0] t_d;
  logic [45:0] pm_unused_w;
  logic [23:0] tq_w;
  logic [23:0] r4_d;
  coeff_t      r5_d;

  assign p_d  = {23'd0, a_i} * {23'd0, b_i};
  assign pm_w = {24'd0, p_q} * {46'd0, BARRETT_M};
  assign {t_d, pm_unused_w} = pm_w;
  // Remainder lies in [0,2q), so only the low 24 bits of p and t*q are needed.
  assign tq_w = t_q * {1'b0, Q};
  assign r4_d = p3_q - tq_w;
  assign r5_d = (r4_d >= {1'b0, Q}) ? 23'(r4_d - {1'b0, Q}) : r4_d[22:0];

  // Product, Barrett quotient estimate, remainder and final conditional subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= '0;
      p3_q <= '0;
      t_q  <= '0;
      r4_q <= '0;
      r5_q <= '0;
    end else begin
      p_q  <= p_d;
      p3_q <= p_q[23:0];
      t_q  <= t_d;
      r4_q <= r4_d;
      r5_q <= (r4_q >= {1'b0, Q}) ? 23'(r4_q - {1'b0, Q}) : r4_q[22:0];
    end
  end

  assign r_o = r5_q;

endmodule

// File: rtl/bu_intt.sv
// rtl/bu_intt.sv - Pipelined Gentleman-Sande inverse-NTT butterfly mod q with optional halving
module bu_intt
  import ntt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 6
) (
  input logic      clk,
  input logic      rst_n,
  bu_intt_if.slave bus
);

  if (LAT != 6) begin : g_bad_lat
    $error("bu_intt: LAT is fixed by the pipeline structure and must be 6");
  end
  if (WIDTH <= COEFF_W) begin : g_bad_width
    $error("bu_intt: WIDTH must exceed the 23-bit coefficient width");
  end

  coeff_t a_w, b_w, w_w;
  logic [3*(WIDTH-COEFF_W)-1:0] in_hi_unused_w;

  assign a_w = bus.A_In[COEFF_W-1:0];
  assign b_w = bus.B_In[COEFF_W-1:0];
  assign w_w = bus.W_In[COEFF_W-1:0];
  assign in_hi_unused_w = {bus.A_In[WIDTH-1:COEFF_W], bus.B_In[WIDTH-1:COEFF_W],
                           bus.W_In[WIDTH-1:COEFF_W]};

  logic [23:0] sum_w, diff_w;
  coeff_t      s_d, d_d;

  assign sum_w  = {1'b0, a_w} + {1'b0, b_w};
  assign diff_w = {1'b0, a_w} - {1'b0, b_w};

  // Stage 1 modular add and subtract (diff_w[23] is the borrow).
  always_comb begin
    s_d = sum_w[22:0];
    d_d = diff_w[22:0];
    if (sum_w >= {1'b0, Q}) s_d = 23'(sum_w - {1'b0, Q});
    if (diff_w[23])         d_d = 23'(diff_w + {1'b0, Q});
  end

  logic [LAT-1:0]       vld_q;
  logic [LAT-2:0]       half_q;
  logic [LAT-2:0][22:0] s_pipe_q;
  coeff_t               d1_q, w1_q;
  coeff_t               r_w;
  coeff_t               a_out_q, b_out_q;

  // Stage 1 registers plus valid/half/sum delay lines matched to the multiplier path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      half_q   <= '0;
      s_pipe_q <= '0;
      d1_q     <= '0;
      w1_q     <= '0;
    end else begin
      vld_q    <= {vld_q[LAT-2:0], bus.in_valid};
      half_q   <= {half_q[LAT-3:0], bus.half_en};
      s_pipe_q <= {s_pipe_q[LAT-3:0], s_d};
      d1_q     <= d_d;
      w1_q     <= w_w;
    end
  end

  mod_mul_q u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (d1_q),
    .b_i   (w1_q),
    .r_o   (r_w)
  );

  // Stage 6: optional halving of both results into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q <= '0;
      b_out_q <= '0;
    end else begin
      a_out_q <= half_mod_q(s_pipe_q[LAT-2], half_q[LAT-2]);
      b_out_q <= half_mod_q(r_w, half_q[LAT-2]);
    end
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.A_Out     = WIDTH'(a_out_q);
  assign bus.B_Out     = WIDTH'(b_out_q);

endmodule

// File: doc/bu_intt.md
Name: bu_intt

Overview:
- Pipelined Gentleman-Sande inverse-NTT butterfly for q = 8380417.
- Per valid sample it computes A_Out = (A+B) mod q and B_Out = ((A−B)·W) mod q, optionally halving both outputs mod q so the n⁻¹ scaling is distributed across INTT layers.
- It is the inverse-direction counterpart of the forward NTT butterfly and feeds the same coefficient memory/scheduler.
- Fully pipelined: one butterfly per clock, fixed latency, no backpressure.

Parameters:
- WIDTH, 32, coefficient/twiddle bus width; only the low 23 bits are significant.
- LAT, 6, input-to-output latency in cycles; fixed by the structure, not tunable (elaboration error if ≠ 6).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  A_In/B_In/W_In/half_en are valid this cycle.
- A_In  input  WIDTH  upper coefficient, must be in [0,q).
- B_In  input  WIDTH  lower coefficient, must be in [0,q).
- W_In  input  WIDTH  inverse twiddle, must be in [0,q).
- half_en  input  1  when 1, both outputs are multiplied by 2⁻¹ mod q.
- out_valid  output  1  A_Out/B_Out carry a result this cycle.
- A_Out  output  WIDTH  (A+B)·(half_en ? 2⁻¹ : 1) mod q, zero-extended.
- B_Out  output  WIDTH  (A−B)·W·(half_en ? 2⁻¹ : 1) mod q, zero-extended.

Behaviour:
- Reset: all pipeline registers clear to 0, including the valid chain, sideband and data. After reset: out_valid=0, A_Out=0, B_Out=0.
- Reset mid-stream discards all in-flight samples. No out_valid may appear for samples accepted before reset.
- Latency: a sample accepted at edge t (in_valid=1) appears at edge t+6 with out_valid=1. in_valid, half_en and the A-path are delayed by shift registers matched to the B-path.
- Stage 1:
  - s = A+B; if s ≥ q then s −= q.
  - d = A−B; if negative then d += q.
  - Register s, d, W.
- Stage 2: p = d·W, a 46-bit product, registered.
- Stage 3: t = (p·M) >> 46, with M = floor(2^46/q) = 8396807; registered along with p.
- Stage 4: r = p − t·q, guaranteed in [0,2q), registered in 24 bits.
- Stage 5: if r ≥ q then r −= q. The delayed s passes through unchanged.
- Stage 6, halving, applied to both s and r when the delayed half_en = 1: x even → x>>1; x odd → (x+q)>>1. Otherwise pass through. Registered into A_Out/B_Out.
- Data registers update every cycle regardless of valid; only out_valid qualifies the outputs.
- in_valid=0 bubbles propagate as out_valid=0 gaps. Back-to-back samples produce back-to-back outputs.
- Inputs ≥ q are outside contract; the result is unspecified, but the block must not hang.
- Boundaries that must hold:
  - A=B gives d=0 and B_Out=0.
  - A+B=2q−2 gives A_Out=q−2.
  - W=0 gives B_Out=0.
  - W=q−1 gives B_Out=(q−d) mod q.

Decomposition:
- Package ntt_pkg holds Q=8380417, BARRETT_M=8396807, BARRETT_K=46, QINV2=4190209 and a coeff_t typedef (23-bit).
- One sub-module, mod_mul_q: stages 2–5, 3-cycle... precisely 4 registers from operands to reduced product. It has a valid-free datapath and is reused by future pointwise-multiply blocks.
- Add/sub, delay lines and halving stay in bu_intt.

Test Plan:
- Single sample A=5, B=3, W=1, half_en=0 → six cycles later out_valid=1, A_Out=8, B_Out=2. out_valid is 0 on all other cycles.
- Wrap cases, half_en=0:
  - A=0, B=1, W=1 → A_Out=1, B_Out=8380416.
  - A=8380416, B=8380416, W=7 → A_Out=8380415, B_Out=0.
- Halving:
  - A=5, B=3, W=1, half_en=1 → A_Out=4, B_Out=1.
  - A=2, B=1, W=8380416, half_en=1 → A_Out=4190210, B_Out=4190208.
- Stream of 1000 back-to-back random in-range samples with random bubbles and random half_en → outputs in order, each matching a reference model exactly, out_valid pattern equal to in_valid delayed by 6.
- Reduction stress: A=8380416, B=0, W=8380416 → B_Out=1. Also exhaustive corners d, W ∈ {0,1,q−2,q−1} → B_Out=(d·W) mod q.
- Assert rst_n low for 1 cycle while 4 samples are in flight → no out_valid for those samples; A_Out=B_Out=0 immediately after reset. A sample issued 1 cycle after release emerges 6 cycles later, correct.
